// File: rtl/id_ex_skid_pkg.sv
// Shared types and constants for the ID/EX skid buffer.
// Write-back bypass is enabled by defining ID_EX_WB_BYPASS_EN.
`include "common.vh"

package id_ex_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [4:0] XZR        = 5'd31;
  localparam int         CTRL_W_DEF = 16;

  // Select write-back data when it targets the operand's register (never XZR).
  function automatic logic [`WORD-1:0] wb_fwd(
    input logic [4:0]       r,
    input logic [`WORD-1:0] d,
    input logic             we,
    input logic [4:0]       wr,
    input logic [`WORD-1:0] wd
  );
    return (we && (wr == r) && (wr != XZR)) ? wd : d;
  endfunction

endpackage

// File: rtl/common.vh
// Shared width definitions for the ID/EX pipeline slice.
`ifndef COMMON_VH
`define COMMON_VH
`define WORD 32
`endif

// File: rtl/id_ex_entry.sv
// One ID/EX entry register with per-operand write-back bypass.
// Bypass behaviour exists only when ID_EX_WB_BYPASS_EN is defined.
`include "common.vh"

module id_ex_entry
  import id_ex_skid_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4:0]        d_r_reg1,
  input  logic [4:0]        d_r_reg2,
  input  logic [4:0]        d_w_reg,
  input  logic [`WORD-1:0]  d_r_data1,
  input  logic [`WORD-1:0]  d_r_data2,
  input  logic [`WORD-1:0]  d_imm,
  input  logic [`WORD-1:0]  d_pc,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_w_reg,
  input  logic [`WORD-1:0]  wb_w_data,
  output logic [4:0]        q_r_reg1,
  output logic [4:0]        q_r_reg2,
  output logic [4:0]        q_w_reg,
  output logic [`WORD-1:0]  q_r_data1,
  output logic [`WORD-1:0]  q_r_data2,
  output logic [`WORD-1:0]  q_imm,
  output logic [`WORD-1:0]  q_pc,
  output logic [CTRL_W-1:0] q_ctrl
);

  logic [`WORD-1:0] load_d1, load_d2, hold_d1, hold_d2;

`ifdef ID_EX_WB_BYPASS_EN
  // Incoming operands and held operands both see the same-cycle write-back.
  assign load_d1 = wb_fwd(d_r_reg1, d_r_data1, wb_reg_write, wb_w_reg, wb_w_data);
  assign load_d2 = wb_fwd(d_r_reg2, d_r_data2, wb_reg_write, wb_w_reg, wb_w_data);
  assign hold_d1 = wb_fwd(q_r_reg1, q_r_data1, wb_reg_write, wb_w_reg, wb_w_data);
  assign hold_d2 = wb_fwd(q_r_reg2, q_r_data2, wb_reg_write, wb_w_reg, wb_w_data);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_w_reg, wb_w_data};
  assign load_d1   = d_r_data1;
  assign load_d2   = d_r_data2;
  assign hold_d1   = q_r_data1;
  assign hold_d2   = q_r_data2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r_reg1  <= '0;
      q_r_reg2  <= '0;
      q_w_reg   <= '0;
      q_r_data1 <= '0;
      q_r_data2 <= '0;
      q_imm     <= '0;
      q_pc      <= '0;
      q_ctrl    <= '0;
    end else if (load) begin
      q_r_reg1  <= d_r_reg1;
      q_r_reg2  <= d_r_reg2;
      q_w_reg   <= d_w_reg;
      q_r_data1 <= load_d1;
      q_r_data2 <= load_d2;
      q_imm     <= d_imm;
      q_pc      <= d_pc;
      q_ctrl    <= d_ctrl;
    end else begin
      q_r_data1 <= hold_d1;
      q_r_data2 <= hold_d2;
    end
  end

endmodule

// File: rtl/id_ex_skid.sv
// Two-entry ID/EX skid buffer: main entry drives EX, skid absorbs one stall.
// Optional write-back bypass is controlled by ID_EX_WB_BYPASS_EN.
`include "common.vh"

module id_ex_skid
  import id_ex_skid_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        id_r_reg1,
  input  logic [4:0]        id_r_reg2,
  input  logic [4:0]        id_w_reg,
  input  logic [`WORD-1:0]  id_r_data1,
  input  logic [`WORD-1:0]  id_r_data2,
  input  logic [`WORD-1:0]  id_imm,
  input  logic [`WORD-1:0]  id_pc,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_w_reg,
  input  logic [`WORD-1:0]  wb_w_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        ex_r_reg1,
  output logic [4:0]        ex_r_reg2,
  output logic [4:0]        ex_w_reg,
  output logic [`WORD-1:0]  ex_r_data1,
  output logic [`WORD-1:0]  ex_r_data2,
  output logic [`WORD-1:0]  ex_imm,
  output logic [`WORD-1:0]  ex_pc,
  output logic [CTRL_W-1:0] ex_ctrl,
  output state_t            state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready/out_valid are registered and depend only on state.
  logic accept, send;
  assign accept = in_valid & in_ready;
  assign send   = out_valid & out_ready;

  logic load_main, load_skid, main_from_skid;
  assign main_from_skid = (state == FULL);
  assign load_main = ~flush & (((state == EMPTY) & accept) |
                               ((state == ONE) & accept & send) |
                               ((state == FULL) & send));
  assign load_skid = ~flush & (state == ONE) & accept & ~send;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state     <= ONE;
          out_valid <= 1'b1;
        end
        ONE: begin
          if (accept & ~send) begin
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (~accept & send) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: if (send) begin
          state    <= ONE;
          in_ready <= 1'b1;
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  logic [4:0]        s_r_reg1, s_r_reg2, s_w_reg;
  logic [`WORD-1:0]  s_r_data1, s_r_data2, s_imm, s_pc;
  logic [CTRL_W-1:0] s_ctrl;

  id_ex_entry #(.CTRL_W(CTRL_W)) u_skid (
    .clk(clk), .rst(rst_n), .load(load_skid),
    .d_r_reg1(id_r_reg1), .d_r_reg2(id_r_reg2), .d_w_reg(id_w_reg),
    .d_r_data1(id_r_data1), .d_r_data2(id_r_data2),
    .d_imm(id_imm), .d_pc(id_pc), .d_ctrl(id_ctrl),
    .wb_reg_write(wb_reg_write), .wb_w_reg(wb_w_reg), .wb_w_data(wb_w_data),
    .q_r_reg1(s_r_reg1), .q_r_reg2(s_r_reg2), .q_w_reg(s_w_reg),
    .q_r_data1(s_r_data1), .q_r_data2(s_r_data2),
    .q_imm(s_imm), .q_pc(s_pc), .q_ctrl(s_ctrl)
  );

  id_ex_entry #(.CTRL_W(CTRL_W)) u_main (
    .clk(clk), .rst(rst_n), .load(load_main),
    .d_r_reg1 (main_from_skid ? s_r_reg1  : id_r_reg1),
    .d_r_reg2 (main_from_skid ? s_r_reg2  : id_r_reg2),
    .d_w_reg  (main_from_skid ? s_w_reg   : id_w_reg),
    .d_r_data1(main_from_skid ? s_r_data1 : id_r_data1),
    .d_r_data2(main_from_skid ? s_r_data2 : id_r_data2),
    .d_imm    (main_from_skid ? s_imm     : id_imm),
    .d_pc     (main_from_skid ? s_pc      : id_pc),
    .d_ctrl   (main_from_skid ? s_ctrl    : id_ctrl),
    .wb_reg_write(wb_reg_write), .wb_w_reg(wb_w_reg), .wb_w_data(wb_w_data),
    .q_r_reg1(ex_r_reg1), .q_r_reg2(ex_r_reg2), .q_w_reg(ex_w_reg),
    .q_r_data1(ex_r_data1), .q_r_data2(ex_r_data2),
    .q_imm(ex_imm), .q_pc(ex_pc), .q_ctrl(ex_ctrl)
  );

endmodule

// File: doc/id_ex_skid.md
ID_EX_SKID -- requirements
Module: id_ex_skid

Interface
REQ-001 SHALL have parameter CTRL_W, default 16, width of the opaque decoded-control bundle.
REQ-002 SHALL use `WORD from common.vh for all data widths.
REQ-003 SHALL have clk  input  1  rising-edge clock.
REQ-004 SHALL have rst_n  input  1  reset; asynchronous, active-high (1 = reset).
REQ-005 SHALL have in_valid  input  1  ID holds a decoded instruction.
REQ-006 SHALL have in_ready  output  1  stage accepts; registered.
REQ-007 SHALL have id_r_reg1, id_r_reg2, id_w_reg  input  5 each  source/dest register numbers.
REQ-008 SHALL have id_r_data1, id_r_data2, id_imm, id_pc  input  `WORD each  operands, immediate, PC.
REQ-009 SHALL have id_ctrl  input  CTRL_W  control bundle.
REQ-010 SHALL have flush  input  1  discard all held and incoming entries.
REQ-011 SHALL have wb_reg_write  input  1, wb_w_reg  input  5, wb_w_data  input  `WORD  write-back port, same values driven to the register file.
REQ-012 SHALL have out_valid  output  1 and out_ready  input  1  handshake to EX.
REQ-013 SHALL have ex_r_reg1, ex_r_reg2, ex_w_reg (5), ex_r_data1, ex_r_data2, ex_imm, ex_pc (`WORD), ex_ctrl (CTRL_W)  outputs  head entry.

Function
REQ-014 SHALL implement a two-entry skid buffer: main entry drives ex_*; skid entry absorbs one transfer when out_ready drops.
REQ-015 SHALL use states EMPTY, ONE, FULL; in_ready = 1 in EMPTY/ONE, 0 in FULL; out_valid = 1 in ONE/FULL.
REQ-016 Transfers: accept = in_valid & in_ready; send = out_valid & out_ready.
REQ-017 EMPTY: accept -> ONE, entry into main.
REQ-018 ONE: accept & send -> ONE, new entry into main; accept & ~send -> FULL, new entry into skid; ~accept & send -> EMPTY; neither -> hold.
REQ-019 FULL: send -> ONE, skid moves to main; ~send -> hold.
REQ-020 Latency: accepted entry SHALL appear on ex_* the cycle after acceptance when EMPTY or sending.
REQ-021 Ordering SHALL be strictly FIFO; no entry dropped or duplicated except by flush.
REQ-022 flush SHALL force EMPTY next cycle, discard any accept in the same cycle, and take priority over all transitions.
REQ-023 ex_* SHALL hold stable while out_valid & ~out_ready.
REQ-024 Register 31 (XZR) SHALL never be a bypass target.

Reset
REQ-025 rst_n high SHALL immediately force EMPTY, out_valid = 0, in_ready = 1, all ex_* fields 0.
REQ-026 Reset mid-transfer SHALL discard both entries; first post-reset accept enters main.
REQ-027 After rst_n deasserts, acceptance SHALL be possible on the first rising edge.

Configuration
REQ-028 Macro ID_EX_WB_BYPASS_EN SHALL control write-back bypass.
REQ-029 Defined: on capture, if wb_reg_write & wb_w_reg == id_r_regN & wb_w_reg != 31, r_dataN SHALL take wb_w_data; each cycle, held main/skid entries SHALL update r_dataN the same way.
REQ-030 Not defined: operands SHALL be captured and held exactly as presented; wb_* inputs unused.

Structure
REQ-031 Shared package/header SHALL hold state encodings (EMPTY=0, ONE=1, FULL=2), XZR index 31, default CTRL_W.
REQ-032 One sub-module, id_ex_entry (entry register with per-operand bypass compare), SHALL be instantiated twice (main, skid).

Verification
REQ-033 Streaming: out_ready=1, 4 back-to-back accepts, pc 0x0,0x4,0x8,0xC -> same order on ex_pc, one per cycle, in_ready stays 1.
REQ-034 Backpressure: out_ready=0 after pc 0x10 accepted, offer 0x14 -> FULL, in_ready=0; out_ready=1 -> 0x10 then 0x14 output, nothing lost.
REQ-035 Flush: FULL, flush=1 with in_valid=1 (pc 0x20) -> next cycle out_valid=0, in_ready=1, 0x20 never appears.
REQ-036 Bypass (macro on): id_r_reg1=5, id_r_data1=0x1 while wb writes X5=0xAB -> ex_r_data1=0xAB; stalled entry with r_reg2=7 receives wb X7=0x55 -> ex_r_data2=0x55.
REQ-037 XZR/macro off: wb_w_reg=31 matching id_r_reg1=31 -> ex_r_data1 unchanged; macro off, X5 write -> operand unchanged.
REQ-038 Async reset in FULL: rst_n=1 between edges -> out_valid=0 and ex_* = 0 without a clock edge.
